raw2gray: RTL and testbench

Converts the 12-bit Bayer raw pixel stream from the camera capture stage into a half-resolution 12-bit grayscale stream with pixel coordinates. Sits directly upstream of the Sobel shift-register/filter stage and drives its pixel-valid, X/Y and gray inputs. Each 2x2 Bayer quad (G1 R / B G2) of an IMG_W x IMG_H frame becomes one gray pixel, so 1280x960 raw gives 640x480 gray.

---
 rtl/raw2gray_pkg.sv | 24 ++
 rtl/raw2gray_if.sv | 30 +++
 rtl/raw2gray_line_buffer.sv | 44 ++++
 rtl/raw2gray.sv | 182 ++++++++++++++++++
 tb/tb_raw2gray.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raw2gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raw2gray_pkg
//  Description : Shared types and constants for the Bayer-to-gray converter.
//  Revision    : 1.0  initial release
// ============================================================================
package raw2gray_pkg;

    typedef logic [11:0] pixel_t;

    // BT.601-style luma weights, scaled by 256
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

    // Gray coordinate width, raw column counter width, raw row counter width.
    // The row counter is one bit wider than a row index so that it can hold
    // the saturated value IMG_H even when IMG_H is 2048.
    localparam int c_COORD_W = 10;
    localparam int c_RAW_X_W = 11;
    localparam int c_RAW_Y_W = 12;

endpackage
`default_nettype wire

// File: rtl/raw2gray_if.sv
`default_nettype none
// ============================================================================
//  Module      : raw2gray_if
//  Description : Raw Bayer input stream and gray pixel output stream.
//                master = pixel source / gray sink, slave = raw2gray.
//  Revision    : 1.0  initial release
// ============================================================================
interface raw2gray_if;
    import raw2gray_pkg::*;

    logic                 iFVAL;
    logic                 iDVAL;
    pixel_t               iDATA;
    logic                 oDVAL;
    logic [c_COORD_W-1:0] oX;
    logic [c_COORD_W-1:0] oY;
    pixel_t               oGRAY;

    modport master (
        output iFVAL, iDVAL, iDATA,
        input  oDVAL, oX, oY, oGRAY
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA,
        output oDVAL, oX, oY, oGRAY
    );

endinterface
`default_nettype wire

// File: rtl/raw2gray_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : raw2gray_line_buffer
//  Description : One raw line of 12-bit pixels. Simple dual-port RAM with one
//                write port and one registered read port on the same clock.
//                Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module raw2gray_line_buffer
    import raw2gray_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  wire logic          iCLK,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire pixel_t        i_wr_data,
    input  wire logic          i_rd_en,
    input  wire logic [AW-1:0] i_rd_addr,
    output pixel_t             o_rd_data
);

    pixel_t r_mem [0:DEPTH-1];
    pixel_t r_rd_data;

    // Write port: stores the even (top) row of each quad pair of lines
    always_ff @(posedge iCLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: one-cycle registered read used while the odd row streams in
    always_ff @(posedge iCLK) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/raw2gray.sv
`default_nettype none
// ============================================================================
//  Module      : raw2gray
//  Description : Bayer (G1 R / B G2) raw stream to half-resolution 12-bit gray
//                stream with gray X/Y coordinates. One output pulse per quad,
//                two cycles after the quad's bottom-right pixel is accepted.
//                Optional macro RAW2GRAY_LUMA_EN selects weighted luma instead
//                of the plain four-sample average.
//  Revision    : 1.0  initial release
// ============================================================================
module raw2gray
    import raw2gray_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 960
) (
    input  wire logic iCLK,
    input  wire logic iRST,
    raw2gray_if.slave bus
);

    localparam int                   c_AW     = $clog2(IMG_W);
    localparam logic [c_RAW_X_W-1:0] c_X_LAST = c_RAW_X_W'(IMG_W - 1);
    localparam logic [c_RAW_Y_W-1:0] c_Y_END  = c_RAW_Y_W'(IMG_H);

    // Raw position tracking
    logic [c_RAW_X_W-1:0] r_x;
    logic [c_RAW_Y_W-1:0] r_y;
    logic                 r_armed;
    logic                 w_accept;

    // Stage 0: accepted odd-row pixel waiting for its line-buffer read
    logic                 r_s0_vld;
    logic                 r_s0_xodd;
    pixel_t               r_s0_pix;
    logic [c_COORD_W-1:0] r_s0_qx;
    logic [c_COORD_W-1:0] r_s0_qy;

    // Stage 1: quad samples
    logic                 r_s1_vld;
    pixel_t               r_tl;
    pixel_t               r_tr;
    pixel_t               r_bl;
    pixel_t               r_br;
    logic [c_COORD_W-1:0] r_s1_qx;
    logic [c_COORD_W-1:0] r_s1_qy;

    // Stage 2: output registers
    logic                 r_odval;
    logic [c_COORD_W-1:0] r_ox;
    logic [c_COORD_W-1:0] r_oy;
    pixel_t               r_ogray;

    pixel_t               w_rd_data;
    pixel_t               w_gray;

    assign w_accept = bus.iDVAL && bus.iFVAL && r_armed && (r_y < c_Y_END);

    // Raw counters and arming: a frame already running at reset release is skipped
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_x     <= '0;
            r_y     <= '0;
            r_armed <= 1'b0;
        end else if (!bus.iFVAL) begin
            r_x     <= '0;
            r_y     <= '0;
            r_armed <= 1'b1;
        end else if (w_accept) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Even rows fill the buffer; odd rows read back the pixel directly above
    raw2gray_line_buffer #(
        .DEPTH (IMG_W),
        .AW    (c_AW)
    ) u_line_buffer (
        .iCLK      (iCLK),
        .i_wr_en   (w_accept && !r_y[0]),
        .i_wr_addr (r_x[c_AW-1:0]),
        .i_wr_data (bus.iDATA),
        .i_rd_en   (w_accept && r_y[0]),
        .i_rd_addr (r_x[c_AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Stage 0: hold the bottom-row pixel while the top-row read completes
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_s0_vld  <= 1'b0;
            r_s0_xodd <= 1'b0;
            r_s0_pix  <= '0;
            r_s0_qx   <= '0;
            r_s0_qy   <= '0;
        end else begin
            r_s0_vld <= w_accept && r_y[0];
            if (w_accept && r_y[0]) begin
                r_s0_xodd <= r_x[0];
                r_s0_pix  <= bus.iDATA;
                r_s0_qx   <= r_x[c_RAW_X_W-1:1];
                r_s0_qy   <= r_y[c_COORD_W:1];
            end
        end
    end

    // Stage 1: even column latches the left pair, odd column completes the quad
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_s1_vld <= 1'b0;
            r_tl     <= '0;
            r_tr     <= '0;
            r_bl     <= '0;
            r_br     <= '0;
            r_s1_qx  <= '0;
            r_s1_qy  <= '0;
        end else begin
            r_s1_vld <= r_s0_vld && r_s0_xodd;
            if (r_s0_vld && !r_s0_xodd) begin
                r_tl <= w_rd_data;
                r_bl <= r_s0_pix;
            end
            if (r_s0_vld && r_s0_xodd) begin
                r_tr    <= w_rd_data;
                r_br    <= r_s0_pix;
                r_s1_qx <= r_s0_qx;
                r_s1_qy <= r_s0_qy;
            end
        end
    end

`ifdef RAW2GRAY_LUMA_EN
    localparam logic [19:0] c_LR = 20'(LUMA_R);
    localparam logic [19:0] c_LG = 20'(LUMA_G);
    localparam logic [19:0] c_LB = 20'(LUMA_B);

    logic [12:0] w_g_sum;
    pixel_t      w_g;
    logic [19:0] w_luma;

    // Weighted luma from averaged greens; fits 20 bits since weights sum to 256
    assign w_g_sum = {1'b0, r_tl} + {1'b0, r_br};
    assign w_g     = 12'(w_g_sum >> 1);
    assign w_luma  = c_LR * {8'd0, r_tr} + c_LG * {8'd0, w_g} + c_LB * {8'd0, r_bl};
    assign w_gray  = 12'(w_luma >> 8);
`else
    logic [13:0] w_sum;

    // Plain average of the four Bayer samples
    assign w_sum  = {2'b00, r_tl} + {2'b00, r_tr} + {2'b00, r_bl} + {2'b00, r_br};
    assign w_gray = 12'(w_sum >> 2);
`endif

    // Stage 2: register the gray pixel; valid is a single-cycle pulse
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_odval <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_ogray <= '0;
        end else begin
            r_odval <= r_s1_vld;
            if (r_s1_vld) begin
                r_ox    <= r_s1_qx;
                r_oy    <= r_s1_qy;
                r_ogray <= w_gray;
            end
        end
    end

    assign bus.oDVAL = r_odval;
    assign bus.oX    = r_ox;
    assign bus.oY    = r_oy;
    assign bus.oGRAY = r_ogray;

endmodule
`default_nettype wire

// File: tb/tb_raw2gray.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raw2gray
//  Description : Directed self-checking bench for raw2gray on an 8x6 raw frame
//                (4x3 gray). Honors RAW2GRAY_LUMA_EN for expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_raw2gray;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int QW = W / 2;
    localparam int NQ = (W / 2) * (H / 2);

    logic iCLK = 1'b0;
    logic iRST = 1'b0;

    always #5 iCLK = ~iCLK;

    raw2gray_if bus ();

    raw2gray #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc11  = 0;
    int rst_cyc = 0;

    int q_x[$];
    int q_y[$];
    int q_g[$];
    int q_c[$];

    always @(posedge iCLK) cyc <= cyc + 1;

    // Capture every gray pulse away from the active edge
    always @(negedge iCLK) begin
        if (bus.oDVAL === 1'b1) begin
            q_x.push_back(int'(bus.oX));
            q_y.push_back(int'(bus.oY));
            q_g.push_back(int'(bus.oGRAY));
            q_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [11:0] pix(input int mode, input int x, input int y);
        case (mode)
            0: return 12'h800;
            1: return (y % 2 == 0) ? ((x % 2 == 0) ? 12'd100 : 12'd200)
                                   : ((x % 2 == 0) ? 12'd300 : 12'd400);
            2: return 12'hFFF;
            3: return 12'(x);
            default: return 12'(y * 16);
        endcase
    endfunction

    // One frame: iFVAL low (arms), full raw frame, optional extra pixels,
    // optional reset pulse right after raw pixel index rst_at
    task automatic drive_frame(input int mode, input bit gaps, input int rst_at, input int extra);
        int idx;
        idx = 0;
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        repeat (3) tick();
        q_x.delete(); q_y.delete(); q_g.delete(); q_c.delete();
        bus.iFVAL = 1'b1;
        tick();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 1) begin
                        bus.iDVAL = 1'b0;
                        tick();
                    end
                end
                bus.iDVAL = 1'b1;
                bus.iDATA = pix(mode, x, y);
                tick();
                if (x == 1 && y == 1) acc11 = cyc;
                if (idx == rst_at) begin
                    bus.iDVAL = 1'b0;
                    iRST = 1'b0;
                    tick();
                    rst_cyc = cyc;
                    iRST = 1'b1;
                end
                idx++;
            end
        end
        for (int i = 0; i < extra; i++) begin
            bus.iDVAL = 1'b1;
            bus.iDATA = 12'h000;
            tick();
        end
        bus.iDVAL = 1'b0;
        repeat (4) tick();
        bus.iFVAL = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.oDVAL !== 1'b0 || bus.oX !== 10'd0 || bus.oY !== 10'd0 || bus.oGRAY !== 12'd0) begin
            errors++;
            $display("FAIL reset: got dval=%b x=%0d y=%0d g=%0h, want 0 0 0 0",
                     bus.oDVAL, bus.oX, bus.oY, bus.oGRAY);
        end
    endtask

    task automatic test_single_quad();
        int exp_g;
`ifdef RAW2GRAY_LUMA_EN
        exp_g = 240;
`else
        exp_g = 250;
`endif
        drive_frame(1, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ) begin
            errors++;
            $display("FAIL quad_count: got %0d, want %0d", q_g.size(), NQ);
        end
        checks++;
        if (q_c.size() == 0 || q_c[0] != acc11 + 2) begin
            errors++;
            $display("FAIL quad_latency: got cycle %0d, want %0d", (q_c.size() > 0) ? q_c[0] : -1, acc11 + 2);
        end
        for (int i = 0; i < q_g.size(); i++) begin
            checks++;
            if (q_x[i] != i % QW || q_y[i] != i / QW || q_g[i] != exp_g) begin
                errors++;
                $display("FAIL quad[%0d]: got x=%0d y=%0d g=%0d, want x=%0d y=%0d g=%0d",
                         i, q_x[i], q_y[i], q_g[i], i % QW, i / QW, exp_g);
            end
        end
    endtask

    task automatic test_constant();
        drive_frame(0, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ) begin
            errors++;
            $display("FAIL const_count: got %0d, want %0d", q_g.size(), NQ);
        end
        for (int i = 0; i < q_g.size(); i++) begin
            checks++;
            if (q_x[i] != i % QW || q_y[i] != i / QW || q_g[i] != 'h800) begin
                errors++;
                $display("FAIL const[%0d]: got x=%0d y=%0d g=%0h, want x=%0d y=%0d g=800",
                         i, q_x[i], q_y[i], q_g[i], i % QW, i / QW);
            end
        end
        checks++;
        if (q_x.size() == 0 || q_x[q_x.size()-1] != QW - 1 || q_y[q_y.size()-1] != H / 2 - 1) begin
            errors++;
            $display("FAIL const_last: got x=%0d y=%0d, want x=%0d y=%0d",
                     (q_x.size() > 0) ? q_x[q_x.size()-1] : -1,
                     (q_y.size() > 0) ? q_y[q_y.size()-1] : -1, QW - 1, H / 2 - 1);
        end
    endtask

    task automatic test_saturation();
        drive_frame(2, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ) begin
            errors++;
            $display("FAIL sat_count: got %0d, want %0d", q_g.size(), NQ);
        end
        for (int i = 0; i < q_g.size(); i++) begin
            checks++;
            if (q_g[i] != 'hFFF) begin
                errors++;
                $display("FAIL sat[%0d]: got g=%0h, want fff", i, q_g[i]);
            end
        end
    endtask

    // Ramp pixel=x: every quad is {2q, 2q+1, 2q, 2q+1} -> 2q in both modes
    task automatic test_gaps();
        int sx[$];
        int sy[$];
        int sg[$];
        drive_frame(3, 1'b0, -1, 0);
        sx = q_x; sy = q_y; sg = q_g;
        for (int i = 0; i < sg.size(); i++) begin
            checks++;
            if (sx[i] != i % QW || sy[i] != i / QW || sg[i] != 2 * (i % QW)) begin
                errors++;
                $display("FAIL ramp[%0d]: got x=%0d y=%0d g=%0d, want x=%0d y=%0d g=%0d",
                         i, sx[i], sy[i], sg[i], i % QW, i / QW, 2 * (i % QW));
            end
        end
        drive_frame(3, 1'b1, -1, 0);
        checks++;
        if (q_g.size() != NQ || sg.size() != NQ) begin
            errors++;
            $display("FAIL gap_count: got %0d and %0d, want %0d", sg.size(), q_g.size(), NQ);
        end else begin
            for (int i = 0; i < NQ; i++) begin
                checks++;
                if (q_x[i] != sx[i] || q_y[i] != sy[i] || q_g[i] != sg[i]) begin
                    errors++;
                    $display("FAIL gap[%0d]: got x=%0d y=%0d g=%0d, want x=%0d y=%0d g=%0d",
                             i, q_x[i], q_y[i], q_g[i], sx[i], sy[i], sg[i]);
                end
            end
        end
    endtask

    // Row ramp pixel=16*y: average 32qy+8; luma weights red on top row -> 32qy+6
    task automatic test_row_ramp();
        int off;
`ifdef RAW2GRAY_LUMA_EN
        off = 6;
`else
        off = 8;
`endif
        drive_frame(4, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ) begin
            errors++;
            $display("FAIL row_count: got %0d, want %0d", q_g.size(), NQ);
        end
        for (int i = 0; i < q_g.size(); i++) begin
            checks++;
            if (q_y[i] != i / QW || q_g[i] != 32 * (i / QW) + off) begin
                errors++;
                $display("FAIL row[%0d]: got y=%0d g=%0d, want y=%0d g=%0d",
                         i, q_y[i], q_g[i], i / QW, 32 * (i / QW) + off);
            end
        end
    endtask

    // Reset right after raw (3,3) is accepted: that quad and the rest of the
    // frame must never emit; the following frame must be complete
    task automatic test_reset_midframe();
        int late;
        drive_frame(0, 1'b0, 3 * W + 3, 0);
        late = 0;
        for (int i = 0; i < q_c.size(); i++) begin
            if (q_c[i] >= rst_cyc) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rst_mid_pulses: got %0d pulses after reset, want 0", late);
        end
        drive_frame(1, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ || q_x[0] != 0 || q_y[0] != 0) begin
            errors++;
            $display("FAIL rst_next_frame: got %0d pulses first x=%0d y=%0d, want %0d 0 0",
                     q_g.size(), (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1, NQ);
        end
    endtask

    // Pixels beyond the last raw row (data 0) must be ignored
    task automatic test_overrun();
        drive_frame(2, 1'b0, -1, 3 * W);
        checks++;
        if (q_g.size() != NQ) begin
            errors++;
            $display("FAIL overrun_count: got %0d, want %0d", q_g.size(), NQ);
        end
        drive_frame(2, 1'b0, -1, 0);
        checks++;
        if (q_g.size() != NQ || q_x[0] != 0 || q_y[0] != 0 || q_g[0] != 'hFFF) begin
            errors++;
            $display("FAIL overrun_next: got %0d pulses first x=%0d y=%0d g=%0h, want %0d 0 0 fff",
                     q_g.size(), (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1,
                     (q_g.size() > 0) ? q_g[0] : -1, NQ);
        end
    endtask

    initial begin
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iDATA = 12'h000;
        iRST      = 1'b0;
        repeat (3) tick();
        test_reset();
        iRST = 1'b1;
        tick();
        test_single_quad();
        test_constant();
        test_saturation();
        test_gaps();
        test_row_ramp();
        test_reset_midframe();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
